// File: rtl/disp_pkg.sv
// ============================================================================
// Module      : disp_pkg
// Description : Shared types and helpers for the display-sharing arbiter.
//               DISP_DATA_W : width of one display word
//               state_t     : arbiter FSM states (ST_IDLE, ST_SHOW)
//               owner_w()   : width of a requester index
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package disp_pkg;

  localparam int DISP_DATA_W = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int owner_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/disp_rr_pick.sv
// ============================================================================
// Module      : disp_rr_pick
// Description : Combinational round-robin picker. It searches pend_i upward
//               from (last_i+1) mod N_REQ and wraps around. The slot that was
//               served last therefore has the lowest priority.
// Ports       : pend_i  [N_REQ]  pending request flags
//               last_i  [IDX_W]  index granted most recently
//               any_o            at least one request pending
//               grant_o [IDX_W]  selected index (0 when any_o=0)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] pend_i,
  input  logic [IDX_W-1:0] last_i,
  output logic             any_o,
  output logic [IDX_W-1:0] grant_o
);

  int idx;

  // Walk the distances from N_REQ down to 1. The last hit is the closest
  // pending slot after last_i, so no early exit is needed.
  always_comb begin
    any_o   = |pend_i;
    grant_o = '0;
    idx     = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last_i) + k) % N_REQ;
      if (pend_i[idx]) grant_o = IDX_W'(idx);
    end
  end

endmodule

`default_nettype wire

// File: rtl/disp_share_arb.sv
// ============================================================================
// Module      : disp_share_arb
// Description : Round-robin sharing of one 4-digit hex display among N_REQ
//               requesters. Each requester owns a 1-deep slot that it fills
//               over valid/ready. A granted word is shown for DWELL cycles.
// Ports       : clk, rst (async, active-high)
//               i_req_valid [N_REQ]        per-slot push valid
//               i_req_data  [N_REQ*DATA_W] slot i at [i*DATA_W +: DATA_W]
//               o_req_ready [N_REQ]        slot i can accept a push
//               o_data      [DATA_W]       word on display (registered)
//               o_owner     [clog2 N_REQ]  slot that supplied o_data
//               o_busy                     dwell running
// Config      : DISP_ARB_PREEMPT_EN - a pending slot 0 preempts another owner
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_share_arb
  import disp_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DISP_DATA_W,
  parameter int DWELL_W = 24,
  parameter int DWELL   = 12_500_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           i_req_valid,
  input  logic [N_REQ*DATA_W-1:0]    i_req_data,
  output logic [N_REQ-1:0]           o_req_ready,
  output logic [DATA_W-1:0]          o_data,
  output logic [owner_w(N_REQ)-1:0]  o_owner,
  output logic                       o_busy
);

  localparam int                 OW     = owner_w(N_REQ);
  localparam logic [DWELL_W-1:0] RELOAD = DWELL_W'(DWELL - 1);

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    pend_q, pend_d;
  logic [OW-1:0]       last_q, last_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]   slot_q [N_REQ];

  logic [N_REQ-1:0]    accept;
  logic                pick_any;
  logic [OW-1:0]       pick_idx;
  logic                grant_en;
  logic [OW-1:0]       grant_idx;

  // A full slot blocks its own requester, so a grant and an accept never
  // hit the same slot in one cycle.
  assign o_req_ready = rst ? '0 : ~pend_q;
  assign accept      = i_req_valid & ~pend_q;

  assign o_data  = data_q;
  assign o_owner = owner_q;
  assign o_busy  = (state_q == ST_SHOW);

  disp_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (OW)
  ) u_pick (
    .pend_i  (pend_q),
    .last_i  (last_q),
    .any_o   (pick_any),
    .grant_o (pick_idx)
  );

  // Slot storage carries no reset. A slot's content is meaningful only while
  // its pend bit is set.
  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_slot
      always_ff @(posedge clk) begin
        if (accept[i]) slot_q[i] <= i_req_data[i*DATA_W +: DATA_W];
      end
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q | accept;
    last_d    = last_q;
    owner_d   = owner_q;
    data_d    = data_q;
    grant_en  = 1'b0;
    grant_idx = pick_idx;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) grant_en = 1'b1;
      end
      ST_SHOW: begin
        if (cnt_q == '0) begin
          // On dwell expiry, hand over to the next waiting slot without an
          // idle gap.
          if (pick_any) grant_en = 1'b1;
          else          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
`ifdef DISP_ARB_PREEMPT_EN
        if ((owner_q != '0) && pend_q[0]) begin
          grant_en  = 1'b1;
          grant_idx = '0;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant_en) begin
      state_d           = ST_SHOW;
      cnt_d             = RELOAD;
      data_d            = slot_q[grant_idx];
      owner_d           = grant_idx;
      last_d            = grant_idx;
      pend_d[grant_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      last_q  <= OW'(N_REQ - 1);
      owner_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      data_q  <= data_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_disp_share_arb.sv
`default_nettype none

module tb_disp_share_arb;

  localparam int N  = 4;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  i_req_valid = '0;
  logic [N*16-1:0] i_req_data = '0;
  logic [N-1:0]  o_req_ready;
  logic [15:0]   o_data;
  logic [1:0]    o_owner;
  logic          o_busy;

  int vectors    = 0;
  int miscompares = 0;

  disp_share_arb #(
    .N_REQ   (N),
    .DATA_W  (16),
    .DWELL_W (24),
    .DWELL   (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_data      (o_data),
    .o_owner     (o_owner),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The model tracks each slot as (pending, word) and the display as
  // (showing, owner, word, cycles left), and it applies the scheduling rules
  // edge by edge.
  typedef struct {
    logic [15:0] data;
    logic [1:0]  owner;
    logic        busy;
    logic [3:0]  ready;
  } exp_t;

  exp_t        expq[$];
  bit          m_pend[N];
  logic [15:0] m_slot[N];
  int          m_last, m_owner, m_left;
  logic [15:0] m_data;
  bit          m_show;

  function automatic int next_rr();
    for (int k = 1; k <= N; k++)
      if (m_pend[(m_last + k) % N]) return (m_last + k) % N;
    return -1;
  endfunction

  always @(posedge clk) begin
    bit acc[N];
    int g;
    exp_t e;
    if (rst) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_last = N - 1; m_owner = 0; m_data = 16'h0; m_show = 0; m_left = 0;
    end else begin
      for (int i = 0; i < N; i++) acc[i] = i_req_valid[i] && !m_pend[i];
      g = -1;
      if (m_show) begin
        m_left = m_left - 1;
`ifdef DISP_ARB_PREEMPT_EN
        if (m_owner != 0 && m_pend[0]) g = 0;
`endif
        if (g < 0 && m_left == 0) begin
          g = next_rr();
          if (g < 0) m_show = 0;
        end
      end else begin
        g = next_rr();
      end
      if (g >= 0) begin
        m_data = m_slot[g]; m_owner = g; m_last = g;
        m_pend[g] = 0; m_left = DW; m_show = 1;
      end
      for (int i = 0; i < N; i++)
        if (acc[i]) begin
          m_pend[i] = 1;
          m_slot[i] = i_req_data[i*16 +: 16];
        end
    end
    e.data  = m_data;
    e.owner = 2'(m_owner);
    e.busy  = m_show;
    for (int i = 0; i < N; i++) e.ready[i] = rst ? 1'b0 : !m_pend[i];
    expq.push_back(e);
  end

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expq.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL scoreboard_empty: got 0 entries expected >=1");
    end else begin
      e = expq.pop_front();
      check("o_data",      {16'h0, o_data},        {16'h0, e.data});
      check("o_owner",     {30'h0, o_owner},       {30'h0, e.owner});
      check("o_busy",      {31'h0, o_busy},        {31'h0, e.busy});
      check("o_req_ready", {28'h0, o_req_ready},   {28'h0, e.ready});
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input logic [3:0] mask, input logic [15:0] d0, input logic [15:0] d1,
                      input logic [15:0] d2, input logic [15:0] d3);
    i_req_valid = mask;
    i_req_data  = {d3, d2, d1, d0};
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      i_req_valid = '0;
    end
  endtask

  initial begin
    // 1. Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {28'h0, o_req_ready}, 32'h0);
    check("rst_data",  {16'h0, o_data},      32'h0);
    check("rst_busy",  {31'h0, o_busy},      32'h0);
    @(negedge clk); rst = 1'b0; #1;
    check("ready_after_release", {28'h0, o_req_ready}, 32'hF);

    // 2. Single push, latency check
    @(negedge clk); push(4'b0010, 16'h0, 16'hBEEF, 16'h0, 16'h0);
    @(posedge clk);                   // accept edge
    @(negedge clk); i_req_valid = '0;
    @(posedge clk); #2;               // grant edge
    check("beef_data",  {16'h0, o_data},  32'hBEEF);
    check("beef_owner", {30'h0, o_owner}, 32'h1);
    idle_cycles(8);

    // 3. All four at once
    @(negedge clk); push(4'b1111, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    idle_cycles(20);

    // 4. Slot 0 pushes every time it is ready, slot 2 pushes once
    @(negedge clk); push(4'b0101, 16'hA000, 16'h0, 16'hC222, 16'h0);
    repeat (30) begin
      @(negedge clk);
      i_req_valid = 4'b0001;
      i_req_data[15:0] = i_req_data[15:0] + 16'h1;
    end
    idle_cycles(12);

    // 5. Second push to a pending slot 3 is refused
    @(negedge clk); push(4'b0010, 16'h0, 16'h5151, 16'h0, 16'h0);
    @(negedge clk); push(4'b1000, 16'h0, 16'h0, 16'h0, 16'h3A3A);
    @(negedge clk); push(4'b1000, 16'h0, 16'h0, 16'h0, 16'h3B3B);
    #1 check("ready3_blocked", {31'h0, o_req_ready[3]}, 32'h0);
    idle_cycles(6);
    @(negedge clk); push(4'b1000, 16'h0, 16'h0, 16'h0, 16'h3C3C);
    idle_cycles(12);

    // 6. Reset pulse mid-SHOW with slots 1 and 2 pending
    @(negedge clk); push(4'b0001, 16'h0F0F, 16'h0, 16'h0, 16'h0);
    @(negedge clk); i_req_valid = '0;
    @(negedge clk); push(4'b0110, 16'h0, 16'h1616, 16'h2626, 16'h0);
    @(negedge clk); i_req_valid = '0;
    #2 rst = 1'b1;
    #1;
    check("midrst_data",  {16'h0, o_data},      32'h0);
    check("midrst_busy",  {31'h0, o_busy},      32'h0);
    check("midrst_ready", {28'h0, o_req_ready}, 32'h0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    idle_cycles(10);

    // 7. Slot 0 arrives while slot 2 is shown
    @(negedge clk); push(4'b0100, 16'h0, 16'h0, 16'h7272, 16'h0);
    @(posedge clk);
    @(negedge clk); i_req_valid = '0;
    @(posedge clk);                   // slot 2 granted, cnt = DWELL-1
    @(negedge clk); push(4'b0011, 16'h7070, 16'h7171, 16'h0, 16'h0);
    @(posedge clk);                   // slot 0 accepted
    @(negedge clk); i_req_valid = '0;
    @(posedge clk); #2;
`ifdef DISP_ARB_PREEMPT_EN
    check("preempt_owner", {30'h0, o_owner}, 32'h0);
`else
    check("preempt_owner", {30'h0, o_owner}, 32'h2);
`endif
    idle_cycles(16);

    // Randomized traffic, with one asynchronous reset in the middle
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        i_req_valid[i] = ($urandom_range(0, 3) == 0);
        i_req_data[i*16 +: 16] = 16'($urandom);
      end
      if (c == 200) begin
        #1 rst = 1'b1;
        @(negedge clk); rst = 1'b0;
      end
    end
    idle_cycles(24);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
